// File: rtl/mv_best_select.sv
// mv_best_select: picks the minimum-SAE motion vector from a serialised
// candidate stream (one search window per result). Ties on SAE are broken
// by the smaller |vx|+|vy|; equal distance keeps the earlier candidate.
module mv_best_select #(
  parameter int unsigned SAE_W    = 32,
  parameter int unsigned VEC_W    = 6,
  parameter int unsigned NUM_CAND = 961,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SAE_W-1:0] in_sae,
  input  logic [VEC_W-1:0] in_vx,
  input  logic [VEC_W-1:0] in_vy,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAE_W-1:0] out_sae,
  output logic [VEC_W-1:0] out_vx,
  output logic [VEC_W-1:0] out_vy,
  output logic             out_err
);

  typedef enum logic {SCAN, HOLD} state_t;

  localparam logic [CNT_W:0] NUM_CAND_W = NUM_CAND[CNT_W:0];

  state_t           state;
  logic [SAE_W-1:0] bestSae;
  logic [VEC_W-1:0] bestVx;
  logic [VEC_W-1:0] bestVy;
  logic             first;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             take;
  logic [VEC_W:0]   distIn;
  logic [VEC_W:0]   distBest;
  logic [CNT_W:0]   countInc;
  logic [SAE_W-1:0] nextSae;
  logic [VEC_W-1:0] nextVx;
  logic [VEC_W-1:0] nextVy;

  // Magnitude of a signed offset, widened by one bit so the sum cannot wrap
  function automatic logic [VEC_W:0] absExt(input logic [VEC_W-1:0] v);
    logic [VEC_W:0] e;
    e = {v[VEC_W-1], v};
    return v[VEC_W-1] ? (~e + 1'b1) : e;
  endfunction

  // Candidate-vs-best comparison and the folded-in best values
  always_comb begin
    accept   = in_valid && in_ready;
    distIn   = absExt(in_vx) + absExt(in_vy);
    distBest = absExt(bestVx) + absExt(bestVy);
    countInc = {1'b0, count} + 1'b1;
    take     = first || (in_sae < bestSae) ||
               ((in_sae == bestSae) && (distIn < distBest));
    nextSae  = take ? in_sae : bestSae;
    nextVx   = take ? in_vx  : bestVx;
    nextVy   = take ? in_vy  : bestVy;
  end

  // Scan/hold control, best tracking and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_sae   <= '1;
      out_vx    <= '0;
      out_vy    <= '0;
      bestSae   <= '0;
      bestVx    <= '0;
      bestVy    <= '0;
      first     <= 1'b1;
      count     <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (accept) begin
            bestSae <= nextSae;
            bestVx  <= nextVx;
            bestVy  <= nextVy;
            first   <= 1'b0;
            if (count != '1) count <= count + 1'b1;
            if (in_last) begin
              out_sae   <= nextSae;
              out_vx    <= nextVx;
              out_vy    <= nextVy;
              out_err   <= (countInc != NUM_CAND_W);
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            bestSae   <= '0;
            bestVx    <= '0;
            bestVy    <= '0;
            first     <= 1'b1;
            count     <= '0;
            state     <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
